// File: rtl/spike_pkg.sv
// spike_pkg: shared defaults and clog2 helper for the spike queue.
package spike_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_TAGBITS = 3;
  localparam int DEF_DROPBITS = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spike_queue_mem.sv
// spike_queue_mem: DEPTH x TAGBITS storage, sync write, async read, no reset.
module spike_queue_mem #(
  parameter int DEPTH = 8,
  parameter int TAGBITS = 3,
  parameter int AW = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [TAGBITS-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [TAGBITS-1:0] rdata
);
  logic [TAGBITS-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/spike_queue.sv
// spike_queue: circular FIFO of neuron tags with occupancy flags and sticky error stats.
module spike_queue
  import spike_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAGBITS = DEF_TAGBITS,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int DROPBITS = DEF_DROPBITS
) (
  input  logic                 clk,
  input  logic                 asyn_reset_n,
  input  logic                 enq,
  input  logic                 deq,
  input  logic [TAGBITS-1:0]   in_tag,
  input  logic                 flush,
  input  logic                 clr_stat,
  output logic [TAGBITS-1:0]   out_tag,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [clog2(DEPTH):0] count,
  output logic                 overflow,
  output logic                 underflow,
  output logic [DROPBITS-1:0]  drop_count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [TAGBITS-1:0] rd_data;
  logic push_ok, pop_ok, ovf_ev, unf_ev;
  logic [DROPBITS-1:0] drop_inc;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_LEVEL);
  // A full queue still takes a push when the head leaves in the same cycle
  assign push_ok = enq && (!full || deq) && !flush;
  assign pop_ok = deq && !empty && !flush;
  assign ovf_ev = enq && !deq && full && !flush;
  assign unf_ev = deq && !enq && empty && !flush;
  assign drop_inc = &drop_count ? drop_count : drop_count + 1'b1;
  assign out_tag = empty ? '0 : rd_data;
  spike_queue_mem #(.DEPTH(DEPTH), .TAGBITS(TAGBITS), .AW(AW)) u_mem (
    .clk(clk),
    .we(push_ok),
    .waddr(wr_ptr),
    .wdata(in_tag),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge asyn_reset_n)
    if (!asyn_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  // A new error event in the same cycle as clr_stat wins over the clear
  always_ff @(posedge clk or negedge asyn_reset_n)
    if (!asyn_reset_n) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= ovf_ev || (overflow && !clr_stat);
      underflow <= unf_ev || (underflow && !clr_stat);
      drop_count <= ovf_ev ? (clr_stat ? DROPBITS'(1) : drop_inc) : clr_stat ? '0 : drop_count;
    end
endmodule

// File: tb/tb_spike_queue.sv
// tb_spike_queue: directed scenarios plus random traffic against a queue-based model.
module tb_spike_queue;
  logic clk = 0, asyn_reset_n = 0;
  logic enq = 0, deq = 0, flush = 0, clr_stat = 0;
  logic [2:0] in_tag = 0, out_tag;
  logic full, empty, almost_full, overflow, underflow;
  logic [3:0] count;
  logic [7:0] drop_count;
  int vectors = 0, errs = 0;
  int q[$];
  bit m_ovf = 0, m_unf = 0;
  int m_drop = 0;

  spike_queue dut (
    .clk(clk), .asyn_reset_n(asyn_reset_n), .enq(enq), .deq(deq), .in_tag(in_tag),
    .flush(flush), .clr_stat(clr_stat), .out_tag(out_tag), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("out_tag", 32'(out_tag), n > 0 ? q[0] : 0);
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("drop_count", 32'(drop_count), m_drop);
  endtask

  task automatic model_step();
    int n = q.size();
    bit ov = enq && !deq && n == 8 && !flush;
    bit un = deq && !enq && n == 0 && !flush;
    if (flush) q.delete();
    else begin
      bit do_push = enq && (n < 8 || deq);
      if (deq && n > 0) void'(q.pop_front());
      if (do_push) q.push_back(int'(in_tag));
    end
    if (clr_stat) begin
      m_ovf = 0; m_unf = 0; m_drop = 0;
    end
    if (ov) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    if (un) m_unf = 1;
  endtask

  task automatic cyc(input bit e, input bit d, input int t, input bit f = 0, input bit c = 0);
    enq = e; deq = d; in_tag = 3'(t); flush = f; clr_stat = c;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  initial begin
    #3 check_all();
    @(negedge clk) asyn_reset_n = 1;
    // FIFO order 1,2,3 then empty
    for (int i = 1; i <= 3; i++) cyc(1, 0, i);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("drained_tag", 32'(out_tag), 0);
    // fill, then overflow one
    for (int i = 0; i < 8; i++) cyc(1, 0, $urandom_range(0, 7));
    cyc(1, 0, 6);
    chk("ovf_drop1", 32'(drop_count), 1);
    // simultaneous push/pop while full wraps pointers
    for (int i = 0; i < 8; i++) cyc(1, 1, 5);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    // push/pop on empty: push only, no underflow
    cyc(1, 1, 7);
    chk("empty_pp_tag", 32'(out_tag), 7);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("lone_deq_unf", 32'(underflow), 1);
    // flush overrides enq; drop counter saturation
    for (int i = 0; i < 5; i++) cyc(1, 0, i);
    cyc(1, 0, 3, 1);
    chk("flush_empty", 32'(empty), 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, $urandom_range(0, 7));
    for (int i = 0; i < 260; i++) cyc(1, 0, 1);
    chk("drop_sat", 32'(drop_count), 255);
    cyc(1, 0, 2, 0, 1);
    chk("clr_with_event", 32'(drop_count), 1);
    // async reset between edges with count 4
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, i + 2);
    #1 asyn_reset_n = 0;
    q.delete(); m_ovf = 0; m_unf = 0; m_drop = 0;
    #1 check_all();
    #1 asyn_reset_n = 1;
    cyc(1, 0, 4);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 7),
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/spike_queue.md
SPIKE_QUEUE -- requirements
Module: spike_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, 2 or more.
REQ-002 Parameter TAGBITS, default 3, neuron tag width.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold, 1 to DEPTH.
REQ-004 Parameter DROPBITS, default 8, drop counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 asyn_reset_n  input  1  asynchronous, active-low reset.
REQ-007 enq  input  1  push in_tag this cycle.
REQ-008 deq  input  1  pop head entry this cycle.
REQ-009 in_tag  input  TAGBITS  tag to push.
REQ-010 flush  input  1  synchronous discard of all entries.
REQ-011 clr_stat  input  1  synchronous clear of overflow, underflow and drop_count.
REQ-012 out_tag  output  TAGBITS  head entry, first-word-fall-through.
REQ-013 full, empty, almost_full  output  1 each  occupancy flags.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 drop_count  output  DROPBITS  number of rejected pushes, saturating.

Function
REQ-017 Storage SHALL be a circular buffer with separate read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 FIFO order SHALL hold: entries leave in push order. This replaces the earlier fixed-head, stack-like pointer.
REQ-019 out_tag SHALL equal mem[rd_ptr] combinationally when count>0, and 0 when empty.
REQ-020 A push SHALL be accepted when enq=1 and either count<DEPTH, or full with deq=1 in the same cycle.
REQ-021 A pop SHALL be accepted when deq=1 and count>0.
REQ-022 An accepted push SHALL write in_tag at wr_ptr and advance wr_ptr by 1.
REQ-023 An accepted pop SHALL advance rd_ptr by 1.
REQ-024 count SHALL update on the next edge: +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-025 When enq=1, deq=1 and the queue is empty: the push SHALL be accepted, the pop ignored, count becomes 1, and underflow SHALL NOT be set.
REQ-026 When enq=1, deq=1 and the queue is full: both SHALL be accepted, count stays DEPTH, and no drop is recorded.
REQ-027 enq=1 while full with deq=0 SHALL discard in_tag, set overflow, and increment drop_count, saturating at all-ones.
REQ-028 deq=1 while empty with enq=0 SHALL have no effect on state except setting underflow.
REQ-029 Flags SHALL be derived from registered state: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL).
REQ-030 Write-to-read latency SHALL be one cycle: a tag pushed at edge N appears on out_tag after edge N if the queue was empty.
REQ-031 flush=1 SHALL zero both pointers and count at the next edge, overriding enq and deq in that cycle; statistics SHALL be unchanged.
REQ-032 clr_stat=1 SHALL clear overflow, underflow and drop_count at the next edge.
REQ-033 If clr_stat and a new error event occur in the same cycle, the new event SHALL take precedence: flag set, drop_count=1.
REQ-034 A blocking-assignment mix in the sequential process SHALL NOT be used; all registers update non-blocking.

Reset
REQ-035 asyn_reset_n=0 SHALL immediately force: pointers 0, count 0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, drop_count=0, out_tag=0.
REQ-036 Storage contents SHALL NOT require reset; out_tag masking (REQ-019) hides stale data.
REQ-037 Reset asserted mid-operation SHALL discard all queued entries; the first edge after release behaves as an empty queue.

Structure
REQ-038 Default DEPTH, TAGBITS and DROPBITS constants, plus a clog2 helper, SHALL live in shared package spike_pkg.
REQ-039 Storage SHALL be one sub-module, spike_queue_mem: DEPTH x TAGBITS, one synchronous write port and one asynchronous read port, no reset.
REQ-040 Pointer, count and statistics logic SHALL reside in spike_queue.

Verification
REQ-041 Scenario: reset, push tags 1,2,3, then pop three times -> out_tag shows 1,2,3 in order, then empty=1 and out_tag=0.
REQ-042 Scenario: DEPTH=8, push 8 tags, then push 1 more -> full=1, overflow=1, drop_count=1, head tag unchanged.
REQ-043 Scenario: full queue, enq=deq=1 with in_tag=5 for 8 cycles -> count stays 8, no drop, tags exit in order, pointers wrap.
REQ-044 Scenario: empty queue, enq=deq=1 with in_tag=7 -> count=1, out_tag=7, underflow=0; then a lone deq on empty -> underflow=1.
REQ-045 Scenario: count=5 with flush=1 and enq=1 -> count=0, empty=1, drop_count unchanged; push 255+ drops -> drop_count saturates at 255.
REQ-046 Scenario: asyn_reset_n pulsed low between edges with count=4 -> outputs reach reset values without a clock edge; AF_LEVEL=6 gives almost_full=1 exactly at count 6.
